clusterv_wb_sram_target: RTL and testbench

//  Wishbone-tag target that turns one system-interconnect target port into accesses on a

---
 rtl/clusterv_wb_sram_target.sv | 122 ++++++++++++
 tb/tb_clusterv_wb_sram_target.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clusterv_wb_sram_target.sv
// rtl/clusterv_wb_sram_target.sv - classic Wishbone target in front of a single-port synchronous SRAM macro
// Build option: define CLUSTERV_SRAM_ALIAS_EN to alias the whole window onto the SRAM (t_err never raised).
module clusterv_wb_sram_target #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 32,
   parameter int TGA_WIDTH = 1,
   parameter int TGC_WIDTH = 4,
   parameter int TGD_WIDTH = 1,
   parameter int MEM_AW    = 9,
   parameter int WIN_AW    = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [ADR_WIDTH-1:0]   t_adr,
   input  logic [DAT_WIDTH-1:0]   t_dat_w,
   output logic [DAT_WIDTH-1:0]   t_dat_r,
   input  logic                   t_cyc,
   input  logic                   t_stb,
   input  logic                   t_we,
   input  logic [DAT_WIDTH/8-1:0] t_sel,
   output logic                   t_ack,
   output logic                   t_err,
   input  logic [TGD_WIDTH-1:0]   t_tgd_w,
   output logic [TGD_WIDTH-1:0]   t_tgd_r,
   input  logic [TGA_WIDTH-1:0]   t_tga,
   input  logic [TGC_WIDTH-1:0]   t_tgc,
   output logic                   sram_csb,
   output logic                   sram_web,
   output logic [DAT_WIDTH/8-1:0] sram_wmask,
   output logic [MEM_AW-1:0]      sram_addr,
   output logic [DAT_WIDTH-1:0]   sram_din,
   input  logic [DAT_WIDTH-1:0]   sram_dout
);
   typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

   state_t state, state_nxt;
   logic   req;
   logic   in_range;
   logic   ack_nxt;
   logic   err_nxt;
   logic   load_dat;
   logic   unused_inputs;

   assign req = t_cyc & t_stb;

`ifdef CLUSTERV_SRAM_ALIAS_EN
   assign in_range = 1'b1;
`else
   assign in_range = (t_adr[WIN_AW-1:MEM_AW+2] == '0);
`endif

   assign unused_inputs = ^{t_adr[ADR_WIDTH-1:MEM_AW+2], t_adr[1:0], t_tga, t_tgc, t_tgd_w,
                            (WIN_AW < MEM_AW + 2)};

   assign t_tgd_r   = '0;
   assign sram_addr = t_adr[MEM_AW+1:2];
   assign sram_din  = t_dat_w;

   always_comb begin
      state_nxt  = state;
      ack_nxt    = 1'b0;
      err_nxt    = 1'b0;
      load_dat   = 1'b0;
      sram_csb   = 1'b1;
      sram_web   = 1'b1;
      sram_wmask = '0;
      case (state)
         IDLE: begin
            if (req) begin
               if (!in_range) begin
                  err_nxt   = 1'b1;
                  state_nxt = ACK;
               end else begin
                  sram_csb = 1'b0;
                  if (t_we) begin
                     sram_web   = 1'b0;
                     sram_wmask = t_sel;
                     ack_nxt    = 1'b1;
                     state_nxt  = ACK;
                  end else begin
                     state_nxt = RD;
                  end
               end
            end
         end
         // Master may give up while the SRAM read is in flight; drop it silently.
         RD: begin
            if (t_cyc) begin
               load_dat  = 1'b1;
               ack_nxt   = 1'b1;
               state_nxt = ACK;
            end else begin
               state_nxt = IDLE;
            end
         end
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Keep the macro quiet while reset is held, even with a request on the bus.
      if (reset) begin
         sram_csb   = 1'b1;
         sram_web   = 1'b1;
         sram_wmask = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         t_ack   <= 1'b0;
         t_err   <= 1'b0;
         t_dat_r <= '0;
      end else begin
         state <= state_nxt;
         t_ack <= ack_nxt;
         t_err <= err_nxt;
         if (load_dat) begin
            t_dat_r <= sram_dout;
         end
      end
   end
endmodule

// File: tb/tb_clusterv_wb_sram_target.sv
// tb/tb_clusterv_wb_sram_target.sv - randomized self-checking bench for clusterv_wb_sram_target
// Honours CLUSTERV_SRAM_ALIAS_EN the same way as the design.
module tb_clusterv_wb_sram_target;
   typedef struct packed {
      logic        web;
      logic [3:0]  wmask;
      logic [8:0]  addr;
      logic [31:0] din;
   } acc_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] t_adr, t_dat_w, t_dat_r;
   logic        t_cyc, t_stb, t_we, t_ack, t_err;
   logic [3:0]  t_sel;
   logic [0:0]  t_tgd_w, t_tgd_r, t_tga;
   logic [3:0]  t_tgc;
   logic        sram_csb, sram_web;
   logic [3:0]  sram_wmask;
   logic [8:0]  sram_addr;
   logic [31:0] sram_din, sram_dout;

   int checks = 0;
   int errors = 0;
   int cyc_n = 0;
   bit check_en = 1'b0;
   int ack_cnt = 0, err_cnt = 0, csb_cnt = 0;

   logic [31:0] sram_mem [0:511];
   logic [31:0] ref_mem  [0:511];
   logic [31:0] model_datr = 32'h0;
   bit          exp_ack [int];
   bit          exp_err [int];
   acc_t        exp_acc [int];
   logic [31:0] exp_dat [int];

   always #5 clock = ~clock;

   clusterv_wb_sram_target dut (
      .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r),
      .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(t_ack), .t_err(t_err),
      .t_tgd_w(t_tgd_w), .t_tgd_r(t_tgd_r), .t_tga(t_tga), .t_tgc(t_tgc),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // SRAM macro: 1-cycle read latency, byte-masked writes
   always @(posedge clock) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
         end else begin
            sram_dout <= sram_mem[sram_addr];
         end
      end
   end

   always @(posedge clock) cyc_n <= cyc_n + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_n, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (check_en) begin
         if (exp_dat.exists(cyc_n)) model_datr = exp_dat[cyc_n];
         chk("ack", {31'b0, t_ack}, {31'b0, exp_ack.exists(cyc_n) ? 1'b1 : 1'b0});
         chk("err", {31'b0, t_err}, {31'b0, exp_err.exists(cyc_n) ? 1'b1 : 1'b0});
         chk("dat_r", t_dat_r, model_datr);
         chk("tgd_r", {31'b0, t_tgd_r}, 32'h0);
         if (exp_acc.exists(cyc_n)) begin
            chk("csb", {31'b0, sram_csb}, 32'h0);
            chk("web", {31'b0, sram_web}, {31'b0, exp_acc[cyc_n].web});
            chk("wmask", {28'b0, sram_wmask}, {28'b0, exp_acc[cyc_n].wmask});
            chk("addr", {23'b0, sram_addr}, {23'b0, exp_acc[cyc_n].addr});
            chk("din", sram_din, exp_acc[cyc_n].din);
         end else begin
            chk("csb_idle", {31'b0, sram_csb}, 32'h1);
            chk("web_idle", {31'b0, sram_web}, 32'h1);
            chk("wmask_idle", {28'b0, sram_wmask}, 32'h0);
         end
         ack_cnt += int'(t_ack);
         err_cnt += int'(t_err);
         csb_cnt += int'(!sram_csb);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n, input bit cyc_only);
      t_cyc = cyc_only;
      t_stb = 1'b0;
      t_we  = 1'($urandom);
      t_sel = 4'($urandom);
      t_adr = $urandom;
      repeat (n) tick();
   endtask

   // Issues one request at the current cycle N and plays it out for its architectural latency.
   task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit abort, input bit rst_in_rd);
      int         n;
      bit         inr;
      logic [8:0] w;
      n = cyc_n;
      w = adr[10:2];
`ifdef CLUSTERV_SRAM_ALIAS_EN
      inr = 1'b1;
`else
      inr = (adr[13:11] == 3'b0);
`endif
      t_cyc = 1'b1; t_stb = 1'b1; t_we = we; t_adr = adr; t_dat_w = dat; t_sel = sel;
      t_tga = 1'($urandom); t_tgc = 4'($urandom); t_tgd_w = 1'($urandom);
      if (!inr) begin
         exp_err[n+1] = 1'b1;
         tick(); tick();
      end else if (we) begin
         exp_acc[n] = {1'b0, sel, w, dat};
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
         exp_ack[n+1] = 1'b1;
         tick(); tick();
      end else begin
         exp_acc[n] = {1'b1, 4'h0, w, dat};
         tick();
         if (abort) begin
            t_cyc = 1'b0; t_stb = 1'b0;
            tick();
         end else if (rst_in_rd) begin
            reset = 1'b1;
            exp_dat[n+2] = 32'h0;
            tick();
            t_cyc = 1'b0; t_stb = 1'b0;
            tick();
            reset = 1'b0;
         end else begin
            exp_ack[n+2] = 1'b1;
            exp_dat[n+2] = ref_mem[w];
            tick(); tick();
         end
      end
   endtask

   initial begin
      int a0, c0, e0;
      logic [31:0] radr;
      reset = 1'b1;
      t_cyc = 0; t_stb = 0; t_we = 0; t_adr = 0; t_dat_w = 0; t_sel = 0;
      t_tga = 0; t_tgc = 0; t_tgd_w = 0;
      for (int i = 0; i < 512; i++) begin
         sram_mem[i] = $urandom;
         ref_mem[i]  = sram_mem[i];
      end
      @(posedge clock); #1;
      check_en = 1'b1;
      tick();
      chk("reset_ack", {31'b0, t_ack}, 32'h0);
      chk("reset_dat_r", t_dat_r, 32'h0);
      chk("reset_csb", {31'b0, sram_csb}, 32'h1);
      reset = 1'b0;
      idle(1, 1'b0);

      // 1: full write then read back
      xfer(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
      xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
      chk("t1_readback", t_dat_r, 32'hDEAD_BEEF);
      // 2: single-byte write merge
      xfer(1'b1, 32'h8000_0010, 32'h0000_5500, 4'b0010, 1'b0, 1'b0);
      xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b0, 1'b0);
      chk("t2_merge", t_dat_r, 32'hDEAD_55EF);
      // 4: back-to-back writes, stb held
      a0 = ack_cnt; c0 = csb_cnt;
      xfer(1'b1, 32'h0, 32'h1111_1111, 4'hF, 1'b0, 1'b0);
      xfer(1'b1, 32'h4, 32'h2222_2222, 4'hF, 1'b0, 1'b0);
      xfer(1'b1, 32'h8, 32'h3333_3333, 4'hF, 1'b0, 1'b0);
      idle(1, 1'b0);
      chk("t4_acks", ack_cnt - a0, 32'd3);
      chk("t4_csb_cycles", csb_cnt - c0, 32'd3);
      // 3: hole in the window (aliases to word 0 when aliasing is on)
      a0 = ack_cnt; c0 = csb_cnt; e0 = err_cnt;
      xfer(1'b0, 32'h8000_0800, 32'h0, 4'hF, 1'b0, 1'b0);
      idle(1, 1'b0);
`ifdef CLUSTERV_SRAM_ALIAS_EN
      chk("t3_ack", ack_cnt - a0, 32'd1);
      chk("t3_err", err_cnt - e0, 32'd0);
      chk("t3_alias_data", t_dat_r, 32'h1111_1111);
`else
      chk("t3_ack", ack_cnt - a0, 32'd0);
      chk("t3_err", err_cnt - e0, 32'd1);
      chk("t3_csb_cycles", csb_cnt - c0, 32'd0);
`endif
      // 5: abort in RD, then a normal read
      a0 = ack_cnt;
      xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0);
      chk("t5_no_ack", ack_cnt - a0, 32'd0);
      xfer(1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0);
      chk("t5_next_read", t_dat_r, 32'h3333_3333);
      // 6: reset while in RD
      a0 = ack_cnt;
      xfer(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 1'b1);
      idle(3, 1'b1);
      chk("t6_no_ack", ack_cnt - a0, 32'd0);
      chk("t6_dat_r", t_dat_r, 32'h0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         radr = $urandom;
         if (r < 80) radr[13:11] = 3'b0;
         xfer(1'($urandom), radr, $urandom, 4'($urandom), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 29) == 0));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)), 1'($urandom));
      end
      idle(3, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
